hvac_sequencer: RTL and testbench

HVAC_SEQUENCER -- requirements
Module: hvac_sequencer

---
 rtl/hvac_sequencer.sv | 129 ++++++++++++
 tb/tb_hvac_sequencer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/hvac_sequencer.sv
// HVAC heat/cool sequencer: fan pre-purge, min-on drive, post-purge, lockout.
// All drives are Moore decodes of the state register.
module hvac_sequencer #(
    parameter int PRE_CYC     = 4,
    parameter int MIN_ON      = 8,
    parameter int POST_CYC    = 4,
    parameter int LOCKOUT_CYC = 6,
    parameter int CW          = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       heat_req,
    input  logic       cool_req,
    output logic       heating,
    output logic       cooling,
    output logic       fan,
    output logic       busy,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_HEAT = 3'd2;
    localparam logic [2:0] S_COOL = 3'd3;
    localparam logic [2:0] S_POST = 3'd4;
    localparam logic [2:0] S_LOCK = 3'd5;

    logic [2:0]    r_state;
    logic [CW-1:0] r_timer;
    logic          r_mode;
    logic [2:0]    w_nxt;
    logic          w_mode_nxt;
    logic [CW-1:0] w_timer_nxt;
    logic          w_tz;
    logic          w_both;

    assign w_tz   = (r_timer == '0);
    assign w_both = heat_req & cool_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_timer <= w_timer_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    always_comb begin
        w_nxt      = r_state;
        w_mode_nxt = r_mode;
        unique case (r_state)
            S_IDLE: begin
                if (enable && heat_req && !cool_req) begin
                    w_nxt      = S_PRE;
                    w_mode_nxt = 1'b0;
                end else if (enable && cool_req && !heat_req) begin
                    w_nxt      = S_PRE;
                    w_mode_nxt = 1'b1;
                end
            end
            S_PRE: begin
                if (!enable)
                    w_nxt = S_POST;
                else if (w_tz)
                    w_nxt = r_mode ? S_COOL : S_HEAT;
            end
            S_HEAT: begin
                if (!enable || (w_tz && (!heat_req || w_both)))
                    w_nxt = S_POST;
            end
            S_COOL: begin
                if (!enable || (w_tz && (!cool_req || w_both)))
                    w_nxt = S_POST;
            end
            S_POST: begin
                if (w_tz)
                    w_nxt = S_LOCK;
            end
            S_LOCK: begin
                if (w_tz)
                    w_nxt = S_IDLE;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    // Timer reloads on every state change, otherwise counts down to 0.
    always_comb begin
        w_timer_nxt = w_tz ? '0 : r_timer - 1'b1;
        if (w_nxt != r_state) begin
            unique case (w_nxt)
                S_PRE:          w_timer_nxt = CW'(PRE_CYC - 1);
                S_HEAT, S_COOL: w_timer_nxt = CW'(MIN_ON - 1);
                S_POST:         w_timer_nxt = CW'(POST_CYC - 1);
                S_LOCK:         w_timer_nxt = CW'(LOCKOUT_CYC - 1);
                default:        w_timer_nxt = '0;
            endcase
        end
    end

    always_comb begin
        heating = 1'b0;
        cooling = 1'b0;
        fan     = 1'b0;
        busy    = 1'b1;
        unique case (r_state)
            S_PRE:  fan = 1'b1;
            S_HEAT: begin
                heating = 1'b1;
                fan     = 1'b1;
            end
            S_COOL: begin
                cooling = 1'b1;
                fan     = 1'b1;
            end
            S_POST: fan = 1'b1;
            S_LOCK: busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign state = r_state;

endmodule

// File: tb/tb_hvac_sequencer.sv
// Directed bench for hvac_sequencer with default parameters.
// Observed vector is {busy, fan, cooling, heating, state}.
module tb_hvac_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       heat_req;
    logic       cool_req;
    logic       heating;
    logic       cooling;
    logic       fan;
    logic       busy;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] V_IDLE = 7'b0000_000;
    localparam logic [6:0] V_PRE  = 7'b1100_001;
    localparam logic [6:0] V_HEAT = 7'b1101_010;
    localparam logic [6:0] V_COOL = 7'b1110_011;
    localparam logic [6:0] V_POST = 7'b1100_100;
    localparam logic [6:0] V_LOCK = 7'b1000_101;

    hvac_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .heat_req (heat_req),
        .cool_req (cool_req),
        .heating  (heating),
        .cooling  (cooling),
        .fan      (fan),
        .busy     (busy),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {busy, fan, cooling, heating, state};
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [6:0] exp);
        @(posedge clk);
        #1;
        chk(tag, exp);
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        heat_req = 1'b0;
        cool_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", V_IDLE);
        rst = 1'b0;

        // both requests in IDLE: no start
        enable   = 1'b1;
        heat_req = 1'b1;
        cool_req = 1'b1;
        repeat (10) step("idle_conflict", V_IDLE);

        // heat cycle, request dropped at edge 7
        cool_req = 1'b0;
        repeat (4) step("heat_pre", V_PRE);
        repeat (3) step("heat_on", V_HEAT);
        heat_req = 1'b0;
        repeat (5) step("heat_minon", V_HEAT);
        repeat (4) step("heat_post", V_POST);
        repeat (6) step("heat_lock", V_LOCK);
        step("heat_idle", V_IDLE);
        step("heat_idle2", V_IDLE);

        // heat held past min-on, then conflict forces exit
        heat_req = 1'b1;
        repeat (4) step("c_pre", V_PRE);
        repeat (10) step("c_heat_hold", V_HEAT);
        cool_req = 1'b1;
        step("c_conflict_exit", V_POST);
        heat_req = 1'b0;
        repeat (3) step("c_post", V_POST);
        repeat (6) step("c_lock_ignore", V_LOCK);
        step("c_idle", V_IDLE);
        repeat (4) step("cool_pre", V_PRE);
        repeat (2) step("cool_on", V_COOL);

        // abort on 2nd COOL cycle
        enable = 1'b0;
        step("abort_post", V_POST);
        enable   = 1'b1;
        cool_req = 1'b0;
        repeat (3) step("abort_post2", V_POST);
        repeat (6) step("abort_lock", V_LOCK);
        repeat (2) step("abort_idle", V_IDLE);

        // async reset mid-HEAT
        heat_req = 1'b1;
        repeat (4) step("r_pre", V_PRE);
        repeat (2) step("r_heat", V_HEAT);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", V_IDLE);
        heat_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("post_reset_idle", V_IDLE);

        // first request after reset has no lockout
        cool_req = 1'b1;
        step("rst_start", V_PRE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
